// File: rtl/tt_tile_bist_if.sv
// rtl/tt_tile_bist_if.sv - tile BIST bus: run control, tile stimulus/response, status and signature
interface tt_tile_bist_if;
    logic        start;
    logic [7:0]  ui_drive;
    logic [7:0]  uo_sample;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] signature;

    modport master (
        output start, uo_sample,
        input  ui_drive, busy, done, pass, signature
    );

    modport slave (
        input  start, uo_sample,
        output ui_drive, busy, done, pass, signature
    );
endinterface

// File: rtl/tt_tile_bist.sv
// rtl/tt_tile_bist.sv - LFSR-driven tile self-test with 16-bit MISR signature compaction
// Optional: TT_TILE_BIST_SETTLE_EN holds each vector two cycles and samples on the second.
module tt_tile_bist #(
    parameter int          N_VECTORS = 256,
    parameter logic [7:0]  SEED      = 8'hA5,
    parameter logic [15:0] GOLDEN    = 16'h0500
) (
    input  logic           clk,
    input  logic           rst_n,
    tt_tile_bist_if.slave  bus
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1 at launch.
    localparam logic [7:0]  SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [15:0] LAST_IDX = 16'(N_VECTORS - 1);

`ifdef TT_TILE_BIST_SETTLE_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_SETTLE, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
`endif

    state_t      state_q;
    logic [7:0]  lfsr_q, lfsr_d;
    logic [15:0] sig_q, sig_d;
    logic [15:0] count_q;
    logic        busy_q, done_q, pass_q;
    logic        sample_now;

    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        sig_d  = ({sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h1021 : 16'h0000))
                 ^ {8'h00, bus.uo_sample};
`ifdef TT_TILE_BIST_SETTLE_EN
        sample_now = (state_q == S_SETTLE);
`else
        sample_now = (state_q == S_RUN);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lfsr_q  <= SEED;
            sig_q   <= 16'h0000;
            count_q <= 16'h0000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state_q <= S_RUN;
                        lfsr_q  <= SEED_EFF;
                        sig_q   <= 16'h0000;
                        count_q <= 16'h0000;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end
                end
                default: begin
                    // start is deliberately not looked at here: no restart mid-run.
                    if (sample_now) begin
                        sig_q   <= sig_d;
                        lfsr_q  <= lfsr_d;
                        count_q <= count_q + 16'd1;
                        if (count_q == LAST_IDX) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (sig_d == GOLDEN);
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
`ifdef TT_TILE_BIST_SETTLE_EN
                    else begin
                        state_q <= S_SETTLE;
                    end
`endif
                end
            endcase
        end
    end

    assign bus.ui_drive  = busy_q ? lfsr_q : 8'h00;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.signature = sig_q;

endmodule
